branch_resolve_queue: RTL

// - Sits between fetch (branch predictor output) and execute (branch resolution).
// - Fetch pushes one entry per predicted branch: PC, predicted direction, predicted target.
// - Execute resolves branches in program order and the block compares the outcome against the head entry.
// - On mismatch it raises a redirect and flushes wrong-path entries; every resolve returns direction to the predictor.

---
 rtl/branch_resolve_queue.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: holds predicted branches from fetch, checks them against
// in-order resolutions from execute, and raises redirect and predictor updates.
module branch_resolve_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     push_en,
    input  logic [31:0]              push_pc,
    input  logic                     push_pred_taken,
    input  logic [31:0]              push_pred_target,
    input  logic                     resolve_en,
    input  logic                     resolve_taken,
    input  logic [31:0]              resolve_target,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     mispredict,
    output logic [31:0]              redirect_pc,
    output logic                     upd_valid,
    output logic                     upd_taken,
    output logic [31:0]              upd_pc,
    output logic [CNT_W-1:0]         mispredict_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] RECOVER = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } entry_t;

    entry_t mem [DEPTH];

    logic [0:0]       state, state_nxt;
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [OCC_W-1:0] count_nxt;
    logic             push_acc, resolve_acc, mismatch, pop;
    entry_t           head;

    logic             mispredict_nxt, upd_valid_nxt, upd_taken_nxt;
    logic [31:0]      redirect_pc_nxt, upd_pc_nxt;
    logic [CNT_W-1:0] mispredict_cnt_nxt;

    assign head = mem[rd_ptr];

    // State and all registered outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state          <= RUN;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            full           <= 1'b0;
            empty          <= 1'b1;
            mispredict     <= 1'b0;
            redirect_pc    <= '0;
            upd_valid      <= 1'b0;
            upd_taken      <= 1'b0;
            upd_pc         <= '0;
            mispredict_cnt <= '0;
        end else begin
            state          <= state_nxt;
            rd_ptr         <= rd_ptr_nxt;
            wr_ptr         <= wr_ptr_nxt;
            count          <= count_nxt;
            full           <= (count_nxt == OCC_W'(DEPTH));
            empty          <= (count_nxt == '0);
            mispredict     <= mispredict_nxt;
            redirect_pc    <= redirect_pc_nxt;
            upd_valid      <= upd_valid_nxt;
            upd_taken      <= upd_taken_nxt;
            upd_pc         <= upd_pc_nxt;
            mispredict_cnt <= mispredict_cnt_nxt;
        end
    end

    // Entry storage carries no reset; occupancy is tracked by the pointers
    always_ff @(posedge CLK) begin
        if (push_acc) begin
            mem[wr_ptr] <= '{pc: push_pc, pred_taken: push_pred_taken,
                             pred_target: push_pred_target};
        end
    end

    // Next-state, acceptance and output-next logic
    always_comb begin
        state_nxt          = state;
        rd_ptr_nxt         = rd_ptr;
        wr_ptr_nxt         = wr_ptr;
        count_nxt          = count;
        push_acc           = 1'b0;
        resolve_acc        = 1'b0;
        mismatch           = 1'b0;
        pop                = 1'b0;
        mispredict_nxt     = 1'b0;
        redirect_pc_nxt    = '0;
        upd_valid_nxt      = 1'b0;
        upd_taken_nxt      = 1'b0;
        upd_pc_nxt         = '0;
        mispredict_cnt_nxt = mispredict_cnt;

        case (state)
            RUN: begin
                resolve_acc = !flush && resolve_en && (count != '0);
                mismatch    = resolve_acc &&
                              ((head.pred_taken != resolve_taken) ||
                               (resolve_taken && head.pred_target != resolve_target));
                push_acc    = !flush && push_en && !mismatch &&
                              ((count != OCC_W'(DEPTH)) || resolve_acc);
                pop         = resolve_acc && !mismatch;
                if (mismatch) begin
                    state_nxt = RECOVER;
                end
            end
            RECOVER: state_nxt = RUN;
            default: state_nxt = RUN;
        endcase

        if (resolve_acc) begin
            upd_valid_nxt  = 1'b1;
            upd_taken_nxt  = resolve_taken;
            upd_pc_nxt     = head.pc;
            mispredict_nxt = mismatch;
        end

        if (mismatch) begin
            redirect_pc_nxt = resolve_taken ? resolve_target : head.pc + 32'd4;
            rd_ptr_nxt      = '0;
            wr_ptr_nxt      = '0;
            count_nxt       = '0;
            if (mispredict_cnt != {CNT_W{1'b1}}) begin
                mispredict_cnt_nxt = mispredict_cnt + CNT_W'(1);
            end
        end else begin
            rd_ptr_nxt = rd_ptr + PTR_W'(pop);
            wr_ptr_nxt = wr_ptr + PTR_W'(push_acc);
            count_nxt  = count + OCC_W'(push_acc) - OCC_W'(pop);
        end

        // External flush empties the queue and leaves recovery
        if (flush) begin
            state_nxt  = RUN;
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
            count_nxt  = '0;
        end
    end

endmodule
